// File: rtl/latch_scm_multiport_if.sv
// Bus bundle for latch_scm_multiport: N independent read ports, one byte-enabled
// write port and the init-sequencer status flag.
interface latch_scm_multiport_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RPORTS = 2
);
   localparam int NUM_BYTES = DATA_WIDTH / 8;

   logic                             InitBusy;
   logic [NUM_RPORTS-1:0]            ReadEnable;
   logic [NUM_RPORTS*ADDR_WIDTH-1:0] ReadAddr;
   logic [NUM_RPORTS*DATA_WIDTH-1:0] ReadData;
   logic [NUM_RPORTS-1:0]            ReadValid;
   logic                             WriteEnable;
   logic [ADDR_WIDTH-1:0]            WriteAddr;
   logic [DATA_WIDTH-1:0]            WriteData;
   logic [NUM_BYTES-1:0]             WriteBe;

   modport master (
      input  InitBusy, ReadData, ReadValid,
      output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBe
   );

   modport slave (
      output InitBusy, ReadData, ReadValid,
      input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteBe
   );
endinterface

// File: rtl/latch_scm_multiport.sv
// Latch-based standard-cell memory with N read ports, byte-enabled writes through
// per-word/per-byte clock gates, optional write->read bypass and zero-init sequencer.

module tc_clk_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);
   logic en_l;

   // NOTE: always_latch is intentional here; the enable is captured while the clock is
   // low so the gated clock cannot glitch during the high phase.
   always_latch begin
      if (!clk_i) en_l <= en_i | test_en_i;
   end

   assign clk_o = clk_i & en_l;
endmodule

module latch_scm_multiport #(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RPORTS    = 2,
   parameter int BYPASS        = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   latch_scm_multiport_if.slave  bus
);
   localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / 8;

   typedef enum logic {IDLE, INIT} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic                    init_busy;

   // Write stage 1: request registered at the accepting edge (drives gate enables).
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [NUM_BYTES-1:0]    wr_be_q, wr_be_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   // Write stage 2: data held stable while the gated latches are transparent.
   logic [DATA_WIDTH-1:0]   latch_data_q, latch_data_d;

   logic [NUM_RPORTS-1:0]   rd_valid_q, rd_valid_d;
   logic [NUM_RPORTS-1:0]   rd_col_q, rd_col_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q [NUM_RPORTS];
   logic [ADDR_WIDTH-1:0]   rd_addr_d [NUM_RPORTS];

   logic [DATA_WIDTH-1:0]   word_data [NUM_WORDS];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data_all;
   logic                    global_clk;

   // ---------------------------------------------------------------- init FSM
   assign init_busy = (state_q == INIT);

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) state_d = IDLE;
      end
   end

   // ---------------------------------------------------------------- request capture
   always_comb begin
      wr_en_d      = bus.WriteEnable;
      wr_addr_d    = bus.WriteAddr;
      wr_be_d      = bus.WriteBe;
      wr_data_d    = bus.WriteData;
      latch_data_d = wr_data_q;
      if (init_busy) begin
         wr_en_d   = 1'b1;
         wr_addr_d = init_cnt_q;
         wr_be_d   = '1;
         wr_data_d = '0;
      end
      for (int p = 0; p < NUM_RPORTS; p++) begin
         rd_addr_d[p]  = bus.ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
         rd_valid_d[p] = bus.ReadEnable[p] & ~init_busy;
         rd_col_d[p]   = rd_valid_d[p] & wr_en_d & (wr_addr_d == rd_addr_d[p]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (INIT_ON_RESET != 0) ? INIT : IDLE;
         init_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         rd_valid_q <= '0;
         rd_col_q   <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wr_en_q    <= wr_en_d;
         rd_valid_q <= rd_valid_d;
         rd_col_q   <= rd_col_d;
      end
   end

   // NOTE: pure datapath registers and the latch array carry no reset; their contents are
   // qualified by the reset-cleared valid/enable flags (and by the init sequencer).
   always_ff @(posedge clk) begin
      wr_addr_q    <= wr_addr_d;
      wr_be_q      <= wr_be_d;
      wr_data_q    <= wr_data_d;
      latch_data_q <= latch_data_d;
      for (int p = 0; p < NUM_RPORTS; p++) rd_addr_q[p] <= rd_addr_d[p];
   end

   // ---------------------------------------------------------------- storage array
   tc_clk_gating u_global_gate (
      .clk_i     (clk),
      .en_i      (wr_en_q),
      .test_en_i (1'b0),
      .clk_o     (global_clk)
   );

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      logic word_sel;
      assign word_sel = wr_en_q & (wr_addr_q == ADDR_WIDTH'(w));

      for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
         logic       byte_clk;
         logic [7:0] byte_l;

         tc_clk_gating u_byte_gate (
            .clk_i     (global_clk),
            .en_i      (word_sel & wr_be_q[b]),
            .test_en_i (1'b0),
            .clk_o     (byte_clk)
         );

         always_latch begin
            if (byte_clk) byte_l <= latch_data_q[8*b +: 8];
         end

         assign word_data[w][8*b +: 8] = byte_l;
      end
   end

   // ---------------------------------------------------------------- read ports
   // A collision sees the array before the colliding write lands; stage 1 still holds
   // that write, so the enabled bytes are forwarded from there.
   always_comb begin
      rd_data_all = '0;
      rd_word     = '0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
         rd_word = word_data[rd_addr_q[p]];
         if ((BYPASS != 0) && rd_col_q[p]) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
               if (wr_be_q[b]) rd_word[8*b +: 8] = wr_data_q[8*b +: 8];
            end
         end
         if (rd_valid_q[p]) rd_data_all[p*DATA_WIDTH +: DATA_WIDTH] = rd_word;
      end
   end

   assign bus.ReadData  = rd_data_all;
   assign bus.ReadValid = rd_valid_q;
   assign bus.InitBusy  = init_busy;
endmodule
